pwm_encoder: RTL and testbench
==============================

// Module: pwm_encoder
// PURPOSE
//  RC-servo/ESC PWM generator: transmit-side counterpart of the PWM pulse decoder.
//  Takes a pulse width in microseconds and emits one high pulse per frame
//  (default 1000-2000 us high inside a 20 ms frame). It drives motor ESC pins
//  from the flight controller.
//  Width updates are double-buffered and apply only at a frame boundary, so a
//  pulse is never glitched.
// PARAMETERS
//  CLOCK_FREQ   50_000_000  input clock in Hz; CLK_DIV = CLOCK_FREQ/1_000_000 clocks per us
//  FRAME_US     20000       frame period in us (16-bit)
//  MIN_US       1000        lower clamp for the pulse width
//  MAX_US       2000        upper clamp for the pulse width
//  DEFAULT_US   1000        width after reset and on failsafe (motor off)
//  WDOG_FRAMES  25          frames without update before failsafe (only with PWM_WATCHDOG_EN)
// PORTS
//  i_clk          in   1   system clock
//  i_reset        in   1   synchronous, active-high reset
//  i_enable       in   1   1 = generate frames; 0 = output idles low after current pulse
//  i_pwm_value    in   16  requested width in us; bits[15:14] are the decoder guard-error flags
//  i_pwm_valid    in   1   i_pwm_value is presented this cycle
//  o_pwm_ready    out  1   encoder can accept a value (valid&&ready = accept)
//  o_pwm_reject   out  1   1-cycle pulse: accepted word had bits[15:14]!=0 and was discarded
//  o_frame_start  out  1   1-cycle pulse on the clock o_pwm rises for a new frame
//  o_pwm          out  1   registered PWM output
// BEHAVIOUR
//  - Reset values: o_pwm=0, o_pwm_ready=0, o_pwm_reject=0, o_frame_start=0; shadow=active=DEFAULT_US;
//    state=IDLE; tick and us counters=0. o_pwm_ready rises on the first clock after reset releases.
//  - Clock and reset: one clock. Reset is synchronous and active-high. A reset mid-pulse forces
//    o_pwm low on the next edge.
//  - Tick: the tick counter runs 0..CLK_DIV-1; the us tick is asserted when it equals CLK_DIV-1.
//    The counter is held at 0 in IDLE.
//  - Input handshake: o_pwm_ready=1 in every non-reset cycle. On valid&&ready:
//    - If bits[15:14]!=0: drop the word, pulse o_pwm_reject next cycle, keep the shadow register.
//    - Otherwise: shadow <= clamp(value, MIN_US, MAX_US). 0 becomes MIN_US and 0x3FFF becomes MAX_US.
//      Exact MIN and MAX values pass unchanged.
//    - The last accepted word of a frame wins. The active width changes only at a frame start.
//  - FSM IDLE/HIGH/LOW; us_cnt counts 0..FRAME_US-1, incrementing on each us tick:
//    - IDLE: o_pwm=0. When i_enable=1, go to HIGH next cycle with us_cnt=0,
//      active<=shadow, o_pwm=1, o_frame_start=1.
//    - HIGH: on the us tick with us_cnt==active-1, o_pwm<=0 and go to LOW.
//      Pulse length is exactly active*CLK_DIV clocks.
//    - LOW: on the us tick with us_cnt==FRAME_US-1:
//      - If i_enable=1: us_cnt<=0, active<=shadow, o_pwm<=1, o_frame_start, go to HIGH.
//      - Else go to IDLE.
//  - i_enable=0 during HIGH completes the pulse and the frame, then goes to IDLE. Pulses are never
//    truncated.
//  - An update that coincides with a frame-start edge applies to the following frame.
//  - Widths are 16-bit unsigned. Parameters must satisfy MAX_US < FRAME_US.
// CONFIGURATION
//  - PWM_WATCHDOG_EN defined:
//    - An 8-bit frame counter clears on each accepted, non-rejected word and increments at each
//      frame start.
//    - When it reaches WDOG_FRAMES, shadow <= DEFAULT_US (saturating) until the next valid word.
//  - Not defined: no counter; the last accepted width is held indefinitely.
// STRUCTURE
//  - pwm_pkg (shared with the decoder):
//    - GUARD_ERROR_LOW=16'hC000 and GUARD_ERROR_HIGH=16'h8000 error masks.
//    - PWM_STATE_IDLE/HIGH/LOW encodings (2-bit).
//    - Default MIN/MAX/FRAME constants.
//  - Sub-module us_tick_gen (CLOCK_FREQ parameter; i_clk, i_reset, i_clear, o_tick) provides the
//    1 us strobe. The decoder's divider will move onto the same sub-module.
// TESTING
//  All scenarios use CLOCK_FREQ=50MHz (CLK_DIV=50).
//  1. Reset, i_enable=1, no write: o_pwm high 50_000 clks, low 950_000 clks, repeating.
//     Frame period is exactly 1_000_000 clks.
//  2. Write 1500 mid-frame: the current frame keeps its old width. The next frame is high 75_000 clks.
//     o_frame_start pulses once per frame.
//  3. Write 500 -> 1000 us; write 2600 -> 2000 us; write 0xC4E2 -> o_pwm_reject pulse and width unchanged.
//  4. Drop i_enable during HIGH: the pulse completes, LOW runs to the frame end, then o_pwm stays 0.
//     Re-enable: a new frame starts the next cycle with o_frame_start.
//  5. Assert i_reset for 1 cycle mid-pulse: o_pwm=0 next edge. After release the width reverts to 1000 us.
//  6. PWM_WATCHDOG_EN: write 1800, then nothing. Frames 1..25 are 1800 us; after that frames are 1000 us.
//     A new write of 1200 restores that width at the next frame.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Definitions shared by the PWM encoder and the PWM pulse decoder:
//             guard-error masks, FSM state encodings, default timing
//             constants and the pulse-width clamp helper.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

    // Bits[15:14] of a width word carry the decoder's guard-error flags.
    localparam logic [15:0] GUARD_ERROR_LOW  = 16'hC000;
    localparam logic [15:0] GUARD_ERROR_HIGH = 16'h8000;

    localparam logic [1:0] PWM_STATE_IDLE = 2'd0;
    localparam logic [1:0] PWM_STATE_HIGH = 2'd1;
    localparam logic [1:0] PWM_STATE_LOW  = 2'd2;

    localparam int PWM_DEFAULT_MIN_US   = 1000;
    localparam int PWM_DEFAULT_MAX_US   = 2000;
    localparam int PWM_DEFAULT_FRAME_US = 20000;

    typedef enum logic [1:0] {
        ST_IDLE = PWM_STATE_IDLE,
        ST_HIGH = PWM_STATE_HIGH,
        ST_LOW  = PWM_STATE_LOW
    } pwm_state_t;

    function automatic logic [15:0] pwm_clamp(input logic [15:0] value,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        return (value < lo) ? lo : ((value > hi) ? hi : value);
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : us_tick_gen
//  Purpose  : 1 us strobe generator. Counts 0..CLK_DIV-1 and asserts o_tick
//             while the count equals CLK_DIV-1 (CLK_DIV = CLOCK_FREQ / 1 MHz).
//  Ports    : i_clk   - system clock
//             i_reset - synchronous active-high reset
//             i_clear - holds the divider at 0 while high
//             o_tick  - 1 us strobe
//  Revision : 1.0  initial release
// ============================================================================
module us_tick_gen #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              CLK_DIV = CLOCK_FREQ / 1_000_000;
    localparam int              CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   C_LAST  = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == C_LAST);

endmodule : us_tick_gen
`default_nettype wire

// File: rtl/pwm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_encoder
//  Purpose  : RC-servo / ESC PWM generator. Emits one high pulse of the
//             active width (us) at the start of every FRAME_US frame. Width
//             words are clamped to MIN_US..MAX_US into a shadow register that
//             is copied to the active width only at a frame start.
//  Config   : `define PWM_WATCHDOG_EN to fall back to DEFAULT_US after
//             WDOG_FRAMES frame starts without a valid word.
//  Ports    : i_clk         - system clock
//             i_reset       - synchronous active-high reset
//             i_enable      - generate frames (0: idle after current frame)
//             i_pwm_value   - width in us, bits[15:14] = guard-error flags
//             i_pwm_valid   - i_pwm_value presented
//             o_pwm_ready   - encoder accepts words (valid&&ready = accept)
//             o_pwm_reject  - 1-cycle pulse: accepted word had guard error
//             o_frame_start - 1-cycle pulse coincident with o_pwm rising
//             o_pwm         - registered PWM output
//  Revision : 1.0  initial release
// ============================================================================
module pwm_encoder
    import pwm_pkg::*;
#(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int FRAME_US    = PWM_DEFAULT_FRAME_US,
    parameter int MIN_US      = PWM_DEFAULT_MIN_US,
    parameter int MAX_US      = PWM_DEFAULT_MAX_US,
    parameter int DEFAULT_US  = 1000,
    parameter int WDOG_FRAMES = 25
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [15:0] i_pwm_value,
    input  logic        i_pwm_valid,
    output logic        o_pwm_ready,
    output logic        o_pwm_reject,
    output logic        o_frame_start,
    output logic        o_pwm
);

    localparam logic [15:0] C_FRAME_LAST = 16'(FRAME_US - 1);
    localparam logic [15:0] C_MIN        = 16'(MIN_US);
    localparam logic [15:0] C_MAX        = 16'(MAX_US);
    localparam logic [15:0] C_DEFAULT    = 16'(DEFAULT_US);

    if (MAX_US >= FRAME_US || MIN_US < 1 || WDOG_FRAMES > 255) begin : g_param_check
        $error("pwm_encoder: parameters need 1 <= MIN_US, MAX_US < FRAME_US, WDOG_FRAMES <= 255");
    end

    pwm_state_t  r_state;
    pwm_state_t  w_state_nxt;
    logic [15:0] r_us_cnt;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic        r_ready;
    logic        r_reject;
    logic        r_frame_start;
    logic        r_pwm;
    logic        w_tick;
    logic        w_tick_clear;
    logic        w_accept;
    logic        w_guard_err;
    logic        w_frame_start;
    logic        w_pulse_end;

    // Divider is parked at 0 in IDLE so the first us of a frame is full length.
    assign w_tick_clear = (r_state == ST_IDLE);

    us_tick_gen #(
        .CLOCK_FREQ (CLOCK_FREQ)
    ) u_us_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_tick_clear),
        .o_tick  (w_tick)
    );

    assign w_accept    = i_pwm_valid && r_ready;
    assign w_guard_err = |(i_pwm_value & GUARD_ERROR_LOW);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_pulse_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick && (r_us_cnt == (r_active - 16'd1))) begin
                    w_pulse_end = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick && (r_us_cnt == C_FRAME_LAST)) begin
                    if (i_enable) begin
                        w_frame_start = 1'b1;
                        w_state_nxt   = ST_HIGH;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Datapath / outputs ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pwm         <= 1'b0;
            r_ready       <= 1'b0;
            r_reject      <= 1'b0;
            r_frame_start <= 1'b0;
            r_us_cnt      <= '0;
            r_active      <= C_DEFAULT;
        end else begin
            r_ready       <= 1'b1;
            r_reject      <= w_accept && w_guard_err;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                // Shadow sampled here, so a word accepted on this same edge
                // lands in the following frame.
                r_us_cnt <= '0;
                r_active <= r_shadow;
                r_pwm    <= 1'b1;
            end else begin
                if (w_pulse_end) begin
                    r_pwm <= 1'b0;
                end
                if (r_state == ST_IDLE) begin
                    r_us_cnt <= '0;
                end else if (w_tick) begin
                    r_us_cnt <= r_us_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- Shadow register ----------------
`ifdef PWM_WATCHDOG_EN
    localparam logic [7:0] C_WDOG = 8'(WDOG_FRAMES);
    logic [7:0] r_wdog_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow   <= C_DEFAULT;
            r_wdog_cnt <= '0;
        end else if (w_accept && !w_guard_err) begin
            r_shadow   <= pwm_clamp(i_pwm_value, C_MIN, C_MAX);
            r_wdog_cnt <= '0;
        end else begin
            if (w_frame_start && (r_wdog_cnt != 8'hFF)) begin
                r_wdog_cnt <= r_wdog_cnt + 8'd1;
            end
            // Keeps forcing the failsafe width until a fresh word arrives.
            if (r_wdog_cnt >= C_WDOG) begin
                r_shadow <= C_DEFAULT;
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow <= C_DEFAULT;
        end else if (w_accept && !w_guard_err) begin
            r_shadow <= pwm_clamp(i_pwm_value, C_MIN, C_MAX);
        end
    end
`endif

    assign o_pwm         = r_pwm;
    assign o_pwm_ready   = r_ready;
    assign o_pwm_reject  = r_reject;
    assign o_frame_start = r_frame_start;

endmodule : pwm_encoder
`default_nettype wire

// File: tb/tb_pwm_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_encoder
//  Purpose  : Self-checking bench for pwm_encoder. Scaled timing
//             (CLK_DIV=4, 100 us frame, 10..40 us clamp) keeps frames short.
//             Watchdog scenario runs only when PWM_WATCHDOG_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_encoder;

    localparam int CF    = 4_000_000;
    localparam int DIV   = CF / 1_000_000;
    localparam int FRAME = 100;
    localparam int MINW  = 10;
    localparam int MAXW  = 40;
    localparam int DEFW  = 10;
    localparam int WDOG  = 25;
    localparam int F     = FRAME * DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] val   = 16'd0;
    logic        pwm, ready, rej, fs;

    pwm_encoder #(
        .CLOCK_FREQ (CF),
        .FRAME_US   (FRAME),
        .MIN_US     (MINW),
        .MAX_US     (MAXW),
        .DEFAULT_US (DEFW),
        .WDOG_FRAMES(WDOG)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_pwm_value  (val),
        .i_pwm_valid  (valid),
        .o_pwm_ready  (ready),
        .o_pwm_reject (rej),
        .o_frame_start(fs),
        .o_pwm        (pwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: widths in us, frame-level behaviour only.
    int m_shadow, m_active, m_wd;
    bit at_start = 1'b0;

    function automatic void model_reset();
        m_shadow = DEFW;
        m_active = DEFW;
        m_wd     = 0;
    endfunction

    function automatic int model_clamp(int v);
        if (v < MINW) return MINW;
        if (v > MAXW) return MAXW;
        return v;
    endfunction

    function automatic bit model_is_bad(int v);
        return v >= 16384;
    endfunction

    function automatic void model_write(int v);
        if (model_is_bad(v)) return;
        m_shadow = model_clamp(v);
        m_wd     = 0;
    endfunction

    function automatic void model_frame_start();
        m_active = m_shadow;
`ifdef PWM_WATCHDOG_EN
        m_wd = m_wd + 1;
        if (m_wd >= WDOG) m_shadow = DEFW;
`endif
    endfunction

    // One-cycle write; returns the reject flag seen the cycle after accept.
    task automatic drive_word(input logic [15:0] v, output bit r);
        valid = 1'b1;
        val   = v;
        @(negedge clk);
        valid = 1'b0;
        r     = rej;
        model_write(int'(v));
        at_start = 1'b0;
    endtask

    // Measures one whole frame; returns at the negedge where the next frame starts.
    task automatic measure(output int hi, output int per, output int exp_hi, output bit ok);
        int w;
        ok = 1'b1; hi = 0; per = 0; w = 0;
        if (!at_start) begin
            while (!fs && w < 2 * F) begin
                @(negedge clk);
                w++;
            end
            if (!fs) begin
                ok = 1'b0; exp_hi = m_active * DIV;
                return;
            end
            model_frame_start();
        end
        exp_hi = m_active * DIV;
        while (per < 2 * F) begin
            if (pwm) hi++;
            @(negedge clk);
            per++;
            if (fs) break;
        end
        if (fs) begin
            model_frame_start();
            at_start = 1'b1;
        end else begin
            ok = 1'b0;
            at_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pwm !== 1'b0)   begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (rej !== 1'b0)   begin n_fail++; $display("FAIL reset_reject: got %b want 0", rej); end
        n_checks++; if (fs !== 1'b0)    begin n_fail++; $display("FAIL reset_fs: got %b want 0", fs); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", ready); end
        repeat (5) @(negedge clk);
        n_checks++; if (pwm !== 1'b0 || fs !== 1'b0) begin n_fail++; $display("FAIL idle_disabled: pwm=%b fs=%b want 0 0", pwm, fs); end
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (pwm !== 1'b1 || fs !== 1'b1) begin n_fail++; $display("FAIL first_frame_start: pwm=%b fs=%b want 1 1", pwm, fs); end
        model_frame_start();
        at_start = 1'b1;
    endtask

    task automatic test_default_frames();
        int hi, per, eh; bit ok;
        for (int i = 0; i < 2; i++) begin
            measure(hi, per, eh, ok);
            n_checks++; if (!ok)       begin n_fail++; $display("FAIL default_timeout frame %0d", i); end
            n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL default_high frame %0d: got %0d want %0d", i, hi, eh); end
            n_checks++; if (per !== F) begin n_fail++; $display("FAIL default_period frame %0d: got %0d want %0d", i, per, F); end
        end
    endtask

    task automatic test_midframe_update();
        int hi, per, eh; bit ok, r;
        repeat (37) @(negedge clk);
        drive_word(16'd25, r);
        n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL mid_reject: got %b want 0", r); end
        for (int i = 0; i < 2; i++) begin
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh || per !== F) begin
                n_fail++; $display("FAIL midframe frame %0d: high %0d period %0d want %0d %0d", i, hi, per, eh, F);
            end
        end
    endtask

    task automatic test_clamp_reject();
        logic [15:0] tbl [12];
        int hi, per, eh; bit ok, r;
        tbl = '{16'd5, 16'd50, 16'hC4E2, 16'd0, 16'h3FFF, 16'(MINW), 16'(MAXW),
                16'(MINW - 1), 16'(MAXW + 1), 16'h4000, 16'h8000, 16'd27};
        for (int i = 0; i < 12; i++) begin
            drive_word(tbl[i], r);
            n_checks++; if (r !== model_is_bad(int'(tbl[i]))) begin
                n_fail++; $display("FAIL reject_flag word %h: got %b want %b", tbl[i], r, model_is_bad(int'(tbl[i])));
            end
            @(negedge clk);
            n_checks++; if (rej !== 1'b0) begin n_fail++; $display("FAIL reject_width word %h: got %b want 0", tbl[i], rej); end
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh || per !== F) begin
                n_fail++; $display("FAIL clamp after word %h: high %0d period %0d want %0d %0d", tbl[i], hi, per, eh, F);
            end
        end
        measure(hi, per, eh, ok);
        n_checks++; if (!ok || hi !== eh) begin n_fail++; $display("FAIL clamp_last: high %0d want %0d", hi, eh); end
    endtask

    task automatic test_random();
        int hi, per, eh, k, sel; bit ok, r; logic [15:0] v;
        for (int fr = 0; fr < 10; fr++) begin
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(0, 50)) @(negedge clk);
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       v = 16'($urandom_range(0, 60));
                    1:       v = 16'($urandom);
                    2:       v = ($urandom_range(0, 1) != 0) ? 16'(MINW) : 16'(MAXW);
                    default: v = 16'h3FFF;
                endcase
                drive_word(v, r);
                n_checks++; if (r !== model_is_bad(int'(v))) begin
                    n_fail++; $display("FAIL rand_reject word %h: got %b want %b", v, r, model_is_bad(int'(v)));
                end
            end
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh || per !== F) begin
                n_fail++; $display("FAIL rand frame %0d: high %0d period %0d want %0d %0d", fr, hi, per, eh, F);
            end
        end
    endtask

    task automatic test_coincident_update();
        int hi, per, eh; bit ok;
        if (!at_start) measure(hi, per, eh, ok);
        repeat (F - 1) @(negedge clk);
        valid = 1'b1; val = 16'd35;
        @(negedge clk);
        valid = 1'b0;
        n_checks++; if (fs !== 1'b1) begin n_fail++; $display("FAIL coincide_edge: fs %b want 1", fs); end
        model_frame_start();
        model_write(35);
        at_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh) begin
                n_fail++; $display("FAIL coincide frame %0d: high %0d want %0d", i, hi, eh);
            end
        end
    endtask

    task automatic test_enable_drop();
        int hi, nfs, eh, per; bit ok;
        if (!at_start) measure(hi, per, eh, ok);
        eh = m_active * DIV;
        en = 1'b0;
        hi = 0; nfs = 0;
        for (int i = 0; i < 3 * F; i++) begin
            if (pwm) hi++;
            @(negedge clk);
            if (fs) nfs++;
        end
        n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL enable_drop_pulse: high %0d want %0d", hi, eh); end
        n_checks++; if (nfs !== 0 || pwm !== 1'b0) begin
            n_fail++; $display("FAIL enable_drop_idle: starts %0d pwm %b want 0 0", nfs, pwm);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (fs !== 1'b1 || pwm !== 1'b1) begin
            n_fail++; $display("FAIL reenable_start: fs %b pwm %b want 1 1", fs, pwm);
        end
        model_frame_start();
        at_start = 1'b1;
        measure(hi, per, eh, ok);
        n_checks++; if (!ok || hi !== eh || per !== F) begin
            n_fail++; $display("FAIL reenable_frame: high %0d period %0d want %0d %0d", hi, per, eh, F);
        end
    endtask

    task automatic test_reset_midpulse();
        int hi, per, eh; bit ok, r;
        drive_word(16'd33, r);
        measure(hi, per, eh, ok);
        repeat (10) @(negedge clk);
        n_checks++; if (pwm !== 1'b1) begin n_fail++; $display("FAIL pre_reset_high: got %b want 1", pwm); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (pwm !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL midpulse_reset: pwm %b ready %b want 0 0", pwm, ready);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || fs !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_start: ready %b fs %b want 1 1", ready, fs);
        end
        model_frame_start();
        at_start = 1'b1;
        measure(hi, per, eh, ok);
        n_checks++; if (!ok || hi !== DEFW * DIV) begin
            n_fail++; $display("FAIL post_reset_width: high %0d want %0d", hi, DEFW * DIV);
        end
    endtask

`ifdef PWM_WATCHDOG_EN
    task automatic test_watchdog();
        int hi, per, eh; bit ok, r;
        drive_word(16'd30, r);
        for (int i = 0; i <= WDOG + 2; i++) begin
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh) begin
                n_fail++; $display("FAIL wdog frame %0d: high %0d want %0d", i, hi, eh);
            end
        end
        n_checks++; if (eh !== DEFW * DIV) begin n_fail++; $display("FAIL wdog_failsafe: model width %0d want %0d", eh, DEFW * DIV); end
        drive_word(16'd20, r);
        for (int i = 0; i < 2; i++) begin
            measure(hi, per, eh, ok);
            n_checks++; if (!ok || hi !== eh) begin
                n_fail++; $display("FAIL wdog_restore frame %0d: high %0d want %0d", i, hi, eh);
            end
        end
    endtask
`endif

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_default_frames();
        test_midframe_update();
        test_clamp_reject();
        test_random();
        test_coincident_update();
        test_enable_drop();
        test_reset_midpulse();
`ifdef PWM_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_encoder
`default_nettype wire
